cmd_serdes_wrapper: RTL and testbench
=====================================

# cmd_serdes_wrapper

Bit-level CMD-line engine between the SD host command controller and the CMD pad. It serialises a 40-bit command, appends CRC7 and the end bit, and drives the frame MSB-first on the pad. It then captures a 48- or 136-bit response from the pad, checks it, and returns it in parallel. It is the stage the command controller drives through its reset_wrapper, enable_pts_wrapper, enable_stp_wrapper and load_send outputs, and its transmission_complete, reception_complete and pad_response outputs feed back to that controller.

## Interface
- CMD_BITS, 40: command payload width (start, dir, index[5:0], arg[31:0]).
- RESP_BITS, 136: width of the pad_response port.
- sd_clock  in  1  CMD-line clock. The single clock; all logic is on its rising edge.
- reset  in  1  Synchronous, active-high global reset.
- reset_wrapper  in  1  Synchronous, active-high soft reset from the controller. Same effect as reset.
- enable_pts_wrapper  in  1  Enables the transmit path.
- load_send  in  1  Load-and-send request. Sampled only in IDLE with enable_pts_wrapper high.
- command  in  40  Command frame without CRC or end bit. Bit 39 is the start bit.
- enable_stp_wrapper  in  1  Enables the receive path.
- long_response  in  1  1 = 136-bit (R2) response, 0 = 48-bit response. Sampled on entry to RX_WAIT.
- cmd_in  in  1  CMD pad input.
- cmd_out  out  1  CMD pad output. Idles high.
- transmission_complete  out  1  Level. Frame fully shifted out.
- reception_complete  out  1  Level. Response captured; pad_response and crc_error are valid.
- pad_response  out  136  Captured response, right-aligned. For 48-bit responses, bits [135:48] are 0.
- crc_error  out  1  CRC7 mismatch or end bit = 0. Valid while reception_complete is high.

## Operation
- States: IDLE, TX_SHIFT, TX_DONE, RX_WAIT, RX_SHIFT, RX_DONE.
- IDLE:
  - enable_pts_wrapper & load_send -> load {command, 7'b0, 1'b1} into a 48-bit shift register, clear the CRC, go to TX_SHIFT.
  - Otherwise, enable_stp_wrapper -> latch long_response, go to RX_WAIT.
  - Transmit has priority when both enables are high.
- TX_SHIFT:
  - cmd_out = shift register MSB; shift left once per cycle; 6-bit bit counter.
  - CRC7 (x^7+x^3+1, initial value 0) accumulates bits 47..8.
  - When bit 8 has been sent, the CRC is inserted for bits 7..1; bit 0 = 1 (end bit).
  - After bit 0, go to TX_DONE.
- TX_DONE: cmd_out = 1 and transmission_complete = 1. Leave to IDLE when enable_pts_wrapper = 0.
- RX_WAIT:
  - cmd_out = 1.
  - cmd_in = 0 (start bit) -> shift in that 0 and go to RX_SHIFT with the counter set to L-1, where L = 136 if long_response else 48.
  - enable_stp_wrapper = 0 -> return to IDLE.
- RX_SHIFT:
  - Shift cmd_in into the LSB of a 136-bit register each cycle.
  - CRC7 accumulates frame bits L-1..8 for 48-bit responses, and bits 127..8 for 136-bit responses (the start, direction and six reserved bits are excluded).
  - When the counter reaches 0, go to RX_DONE.
- RX_DONE:
  - reception_complete = 1.
  - crc_error = (received bits [7:1] != CRC) | (bit 0 == 0).
  - pad_response holds its value. Leave to IDLE when enable_stp_wrapper = 0.
- reset or reset_wrapper, in any state, including mid-frame:
  - Next state is IDLE, cmd_out = 1, both complete flags = 0, crc_error = 0, pad_response = 0, counters and CRC = 0.
  - A truncated frame is never resumed.
- Enable dropped mid-frame: ignored. The frame completes, then the block waits in the DONE state until the enable is low.

## Timing
- Reset values: cmd_out = 1; transmission_complete = 0; reception_complete = 0; crc_error = 0; pad_response = 0; state = IDLE.
- Transmit: load_send sampled at edge N.
  - Frame bit 47 (start bit 0) is on cmd_out from edge N+1.
  - Frame bit k is on cmd_out from edge N+48-k.
  - transmission_complete rises at edge N+49.
- Receive: start bit sampled at edge M; the last bit is sampled at edge M+L-1.
  - reception_complete, pad_response and crc_error are valid from edge M+L.
- Inputs are registered only by the state machine. No combinational path runs from cmd_in to any output.
- The receive path has no timeout; timeout handling belongs to the controller.

## Test plan
- Reset: assert reset for 2 cycles mid-TX_SHIFT -> cmd_out = 1 and all flags 0 at the next edge. A following load_send transmits a full, fresh frame.
- CMD0: command = 0x4000000000 -> serial stream 0x400000000095, 48 cycles. transmission_complete rises exactly 49 edges after load_send.
- CMD8: command = 0x48000001AA -> stream 0x48000001AA87. Hold enable_pts_wrapper high for 3 extra cycles -> the state stays TX_DONE and cmd_out stays 1.
- R7 receive: long_response = 0, 5 idle-high cycles, then drive 0x08000001AA13 -> pad_response = 0x08000001AA13, crc_error = 0, reception_complete at start edge + 48.
- Corrupted response: same frame with bit 20 flipped -> crc_error = 1. Repeat with the end bit forced to 0 -> crc_error = 1.
- R2 plus soft reset:
  - 136-bit frame, long_response = 1 -> full 136-bit capture, with the CRC computed over bits 127..8.
  - Repeat with reset_wrapper pulsed at bit 60 -> IDLE, pad_response = 0, and reception_complete is never asserted.

Source files
------------

// File: rtl/cmd_serdes_wrapper_if.sv
// cmd_serdes_wrapper_if
// Controller-side bundle between the SD command controller and the CMD-line
// serialiser/deserialiser.
//   enable_pts_wrapper  controller -> engine  transmit path enable
//   load_send           controller -> engine  load-and-send request
//   command             controller -> engine  40-bit command (start bit at MSB)
//   enable_stp_wrapper  controller -> engine  receive path enable
//   long_response       controller -> engine  1 = 136-bit R2, 0 = 48-bit response
//   transmission_complete engine -> controller  frame fully shifted out
//   reception_complete    engine -> controller  response captured
//   pad_response          engine -> controller  right-aligned captured response
//   crc_error             engine -> controller  CRC7 or end-bit error
interface cmd_serdes_wrapper_if #(
    parameter int unsigned CMD_BITS  = 40,
    parameter int unsigned RESP_BITS = 136
);
    logic                 enable_pts_wrapper;
    logic                 load_send;
    logic [CMD_BITS-1:0]  command;
    logic                 enable_stp_wrapper;
    logic                 long_response;
    logic                 transmission_complete;
    logic                 reception_complete;
    logic [RESP_BITS-1:0] pad_response;
    logic                 crc_error;

    modport master (
        output enable_pts_wrapper,
        output load_send,
        output command,
        output enable_stp_wrapper,
        output long_response,
        input  transmission_complete,
        input  reception_complete,
        input  pad_response,
        input  crc_error
    );

    modport slave (
        input  enable_pts_wrapper,
        input  load_send,
        input  command,
        input  enable_stp_wrapper,
        input  long_response,
        output transmission_complete,
        output reception_complete,
        output pad_response,
        output crc_error
    );
endinterface

// File: rtl/cmd_serdes_wrapper.sv
// cmd_serdes_wrapper
// Bit-level CMD-line engine. Serialises a 40-bit command with CRC7 and end bit
// MSB-first onto the pad, then captures a 48- or 136-bit response, checks its
// CRC7 and end bit, and presents it in parallel.
// Ports:
//   sd_clock       CMD-line clock, rising edge only
//   reset          synchronous active-high global reset
//   reset_wrapper  synchronous active-high soft reset from the controller
//   ctrl           controller bundle (slave side), see cmd_serdes_wrapper_if
//   cmd_in         CMD pad input
//   cmd_out        CMD pad output, idles high
// Every output is a flop loaded from the current state, so each output lags
// the state register by one edge and nothing combinational runs from cmd_in.
module cmd_serdes_wrapper #(
    parameter int unsigned CMD_BITS  = 40,
    parameter int unsigned RESP_BITS = 136
) (
    input  logic                sd_clock,
    input  logic                reset,
    input  logic                reset_wrapper,
    cmd_serdes_wrapper_if.slave ctrl,
    input  logic                cmd_in,
    output logic                cmd_out
);

    localparam int unsigned FRAME_BITS = CMD_BITS + 8;
    localparam int unsigned SHORT_BITS = 48;
    localparam int unsigned LONG_BITS  = 136;
    localparam int unsigned CNT_W      = 8;
    localparam int unsigned CRC_W      = 7;
    localparam int unsigned CRC_LO     = 8;    // lowest frame bit covered by CRC
    localparam int unsigned CRC_HI_R2  = 127;  // highest covered bit of an R2

    typedef enum logic [2:0] {
        IDLE,
        TX_SHIFT,
        TX_DONE,
        RX_WAIT,
        RX_SHIFT,
        RX_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [FRAME_BITS-1:0] tx_sreg_q, tx_sreg_d;
    logic [RESP_BITS-1:0]  rx_sreg_q, rx_sreg_d;
    logic [RESP_BITS-1:0]  rx_shifted;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CRC_W-1:0]      crc_q, crc_d;
    logic                  long_q, long_d;
    logic                  cmd_out_q, cmd_out_d;
    logic                  tx_cmpl_q, tx_cmpl_d;
    logic                  rx_cmpl_q, rx_cmpl_d;
    logic                  crc_err_q, crc_err_d;

    // One CRC7 (x^7 + x^3 + 1) update for a single serial bit.
    function automatic logic [CRC_W-1:0] crc7_step(input logic [CRC_W-1:0] crc,
                                                   input logic din);
        logic fb;
        fb = crc[CRC_W-1] ^ din;
        return {crc[CRC_W-2:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
    endfunction

    assign rx_shifted = {rx_sreg_q[RESP_BITS-2:0], cmd_in};

    // Next-state and next-register computation.
    always_comb begin
        state_d   = state_q;
        tx_sreg_d = tx_sreg_q;
        rx_sreg_d = rx_sreg_q;
        cnt_d     = cnt_q;
        crc_d     = crc_q;
        long_d    = long_q;
        cmd_out_d = 1'b1;
        tx_cmpl_d = 1'b0;
        rx_cmpl_d = 1'b0;
        crc_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (ctrl.enable_pts_wrapper && ctrl.load_send) begin
                    tx_sreg_d = {ctrl.command, 7'd0, 1'b1};
                    cnt_d     = CNT_W'(FRAME_BITS - 1);
                    crc_d     = '0;
                    state_d   = TX_SHIFT;
                end else if (ctrl.enable_stp_wrapper) begin
                    long_d    = ctrl.long_response;
                    rx_sreg_d = '0;
                    state_d   = RX_WAIT;
                end
            end

            // cnt_q is the frame index of the bit at the shift-register MSB.
            TX_SHIFT: begin
                cmd_out_d = tx_sreg_q[FRAME_BITS-1];
                if (cnt_q >= CNT_W'(CRC_LO)) begin
                    crc_d = crc7_step(crc_q, tx_sreg_q[FRAME_BITS-1]);
                end
                tx_sreg_d = tx_sreg_q << 1;
                // After bit 8 the zeroed CRC field, bits 7..1, is loaded with
                // the finished CRC; the end bit below it is already 1.
                if (cnt_q == CNT_W'(CRC_LO)) begin
                    tx_sreg_d[FRAME_BITS-1 -: CRC_W] = crc_d;
                end
                if (cnt_q == '0) begin
                    state_d = TX_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            TX_DONE: begin
                tx_cmpl_d = 1'b1;
                if (!ctrl.enable_pts_wrapper) begin
                    state_d = IDLE;
                end
            end

            // The start bit is frame bit L-1; stepping a zero CRC with a zero
            // bit leaves it zero, so clearing the CRC covers the start bit.
            RX_WAIT: begin
                if (!cmd_in) begin
                    rx_sreg_d = rx_shifted;
                    cnt_d     = long_q ? CNT_W'(LONG_BITS - 1) : CNT_W'(SHORT_BITS - 1);
                    crc_d     = '0;
                    state_d   = RX_SHIFT;
                end else if (!ctrl.enable_stp_wrapper) begin
                    state_d = IDLE;
                end
            end

            // The bit sampled here is frame bit cnt_q-1.
            RX_SHIFT: begin
                rx_sreg_d = rx_shifted;
                if ((cnt_q > CNT_W'(CRC_LO)) && (cnt_q <= CNT_W'(CRC_HI_R2 + 1))) begin
                    crc_d = crc7_step(crc_q, cmd_in);
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RX_DONE;
                end
            end

            RX_DONE: begin
                rx_cmpl_d = 1'b1;
                crc_err_d = (rx_sreg_q[CRC_W:1] != crc_q) || !rx_sreg_q[0];
                if (!ctrl.enable_stp_wrapper) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; either reset aborts any frame in progress.
    always_ff @(posedge sd_clock) begin
        if (reset || reset_wrapper) begin
            state_q   <= IDLE;
            tx_sreg_q <= '0;
            rx_sreg_q <= '0;
            cnt_q     <= '0;
            crc_q     <= '0;
            long_q    <= 1'b0;
            cmd_out_q <= 1'b1;
            tx_cmpl_q <= 1'b0;
            rx_cmpl_q <= 1'b0;
            crc_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_sreg_q <= tx_sreg_d;
            rx_sreg_q <= rx_sreg_d;
            cnt_q     <= cnt_d;
            crc_q     <= crc_d;
            long_q    <= long_d;
            cmd_out_q <= cmd_out_d;
            tx_cmpl_q <= tx_cmpl_d;
            rx_cmpl_q <= rx_cmpl_d;
            crc_err_q <= crc_err_d;
        end
    end

    assign cmd_out                    = cmd_out_q;
    assign ctrl.transmission_complete = tx_cmpl_q;
    assign ctrl.reception_complete    = rx_cmpl_q;
    assign ctrl.pad_response          = rx_sreg_q;
    assign ctrl.crc_error             = crc_err_q;

endmodule

// File: tb/tb_cmd_serdes_wrapper.sv
// Self-checking bench for cmd_serdes_wrapper: directed command transmits and
// response receives, with a frame-level model (CRC7 by polynomial division)
// and a per-cycle compare process.
module tb_cmd_serdes_wrapper;

    logic sd_clock = 1'b0;
    logic reset = 1'b1;
    logic reset_wrapper = 1'b0;
    logic cmd_in = 1'b1;
    logic cmd_out;

    cmd_serdes_wrapper_if ctrl_if ();

    cmd_serdes_wrapper dut (
        .sd_clock      (sd_clock),
        .reset         (reset),
        .reset_wrapper (reset_wrapper),
        .ctrl          (ctrl_if),
        .cmd_in        (cmd_in),
        .cmd_out       (cmd_out)
    );

    always #5 sd_clock = ~sd_clock;

    int total = 0;
    int bad = 0;

    // Expected post-edge values, set #1 after each rising edge by the stimulus.
    logic         chk_en = 1'b0;
    logic         chk_flags = 1'b1;
    logic         chk_data = 1'b0;
    logic         exp_out = 1'b1;
    logic         exp_tc = 1'b0;
    logic         exp_rc = 1'b0;
    logic         exp_err = 1'b0;
    logic [135:0] exp_resp = '0;

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // CRC7 as the remainder of msg(x) * x^7 divided by x^7 + x^3 + 1.
    function automatic logic [6:0] crc7_of(input logic [119:0] msg, input int nbits);
        logic [127:0] d;
        d = {8'd0, msg} << 7;
        for (int i = nbits + 6; i >= 7; i--) begin
            if (d[i]) d[i -: 8] = d[i -: 8] ^ 8'h89;
        end
        return d[6:0];
    endfunction

    task automatic step();
        @(posedge sd_clock);
        #1;
    endtask

    // Per-cycle compare against the expectations.
    always @(negedge sd_clock) begin
        if (chk_en) begin
            check("cmd_out", 136'(cmd_out), 136'(exp_out));
            if (chk_flags) begin
                check("transmission_complete", 136'(ctrl_if.transmission_complete), 136'(exp_tc));
                check("reception_complete", 136'(ctrl_if.reception_complete), 136'(exp_rc));
            end
            if (chk_data) begin
                check("crc_error", 136'(ctrl_if.crc_error), 136'(exp_err));
                check("pad_response", ctrl_if.pad_response, exp_resp);
            end
        end
    end

    // Transmit one command; lit_stream is the hand-computed serial frame.
    task automatic tx_frame(input logic [39:0] cmd, input logic [47:0] lit_stream, input int extra);
        logic [47:0] frame;
        logic [47:0] stream;
        int tc_idx;
        frame = {cmd, crc7_of(120'(cmd), 40), 1'b1};
        ctrl_if.enable_pts_wrapper = 1'b1;
        ctrl_if.load_send = 1'b1;
        ctrl_if.command = cmd;
        step();                                   // load edge N
        ctrl_if.load_send = 1'b0;
        exp_out = 1'b1;
        stream = '0;
        for (int j = 1; j <= 48; j++) begin       // frame bit 48-j from edge N+j
            step();
            exp_out = frame[48-j];
            stream = {stream[46:0], cmd_out};
        end
        tc_idx = -1;
        for (int j = 49; j <= 60; j++) begin
            step();
            exp_out = 1'b1;
            exp_tc = 1'b1;
            if (ctrl_if.transmission_complete) begin
                tc_idx = j;
                break;
            end
        end
        check("tx_complete_latency", 136'(tc_idx), 136'(49));
        check("tx_stream", 136'(stream), 136'(lit_stream));
        repeat (extra) step();
        ctrl_if.enable_pts_wrapper = 1'b0;
        step();
        chk_flags = 1'b0;                         // complete flag lags the state by one edge
        step();
        chk_flags = 1'b1;
        exp_tc = 1'b0;
    endtask

    // Start a transmit, then apply global reset for two cycles mid-frame.
    task automatic tx_abort(input logic [39:0] cmd, input int nbits);
        logic [47:0] frame;
        frame = {cmd, crc7_of(120'(cmd), 40), 1'b1};
        ctrl_if.enable_pts_wrapper = 1'b1;
        ctrl_if.load_send = 1'b1;
        ctrl_if.command = cmd;
        step();
        ctrl_if.load_send = 1'b0;
        for (int j = 1; j <= nbits; j++) begin
            step();
            exp_out = frame[48-j];
        end
        reset = 1'b1;
        step();
        exp_out = 1'b1;
        exp_tc = 1'b0;
        exp_rc = 1'b0;
        exp_err = 1'b0;
        exp_resp = '0;
        chk_data = 1'b1;
        step();
        reset = 1'b0;
        ctrl_if.enable_pts_wrapper = 1'b0;
        repeat (3) step();
        chk_data = 1'b0;
    endtask

    // Receive one frame; rst_idx >= 0 pulses reset_wrapper with that bit.
    task automatic rx_frame(input logic [135:0] frame, input logic long_r, input int rst_idx,
                            input logic lit_chk, input logic [135:0] lit_resp, input logic lit_err);
        int n;
        int k_seen;
        logic aborted;
        logic [135:0] mresp;
        logic [119:0] msg;
        logic merr;
        n = long_r ? 136 : 48;
        mresp = long_r ? frame : (frame & {88'd0, {48{1'b1}}});
        msg = long_r ? frame[127:8] : 120'(frame[47:8]);
        merr = (frame[7:1] != crc7_of(msg, long_r ? 120 : 40)) || !frame[0];
        ctrl_if.enable_stp_wrapper = 1'b1;
        ctrl_if.long_response = long_r;
        cmd_in = 1'b1;
        step();
        repeat (5) step();                        // idle-high line
        aborted = 1'b0;
        for (int j = 0; j < n; j++) begin         // start bit sampled at j = 0
            cmd_in = frame[n-1-j];
            if (j == rst_idx) begin
                reset_wrapper = 1'b1;
                ctrl_if.enable_stp_wrapper = 1'b0;
            end
            step();
            if (j == rst_idx) begin
                reset_wrapper = 1'b0;
                aborted = 1'b1;
                exp_resp = '0;
                exp_err = 1'b0;
                chk_data = 1'b1;
            end
        end
        cmd_in = 1'b1;
        if (aborted) begin
            repeat (3) step();
            check("rx_abort_response", ctrl_if.pad_response, '0);
            chk_data = 1'b0;
        end else begin
            k_seen = -1;
            for (int k = n; k < n + 8; k++) begin
                step();
                exp_rc = 1'b1;
                exp_resp = mresp;
                exp_err = merr;
                chk_data = 1'b1;
                if (ctrl_if.reception_complete) begin
                    k_seen = k;
                    break;
                end
            end
            check("rx_complete_latency", 136'(k_seen), 136'(n));
            if (lit_chk) begin
                check("rx_response_literal", ctrl_if.pad_response, lit_resp);
                check("rx_crc_error_literal", 136'(ctrl_if.crc_error), 136'(lit_err));
            end
            repeat (2) step();
            ctrl_if.enable_stp_wrapper = 1'b0;
            step();
            chk_flags = 1'b0;
            chk_data = 1'b0;
            step();
            chk_flags = 1'b1;
            exp_rc = 1'b0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [135:0] r7;
        logic [135:0] r2;
        logic [119:0] cid;
        ctrl_if.enable_pts_wrapper = 1'b0;
        ctrl_if.load_send = 1'b0;
        ctrl_if.command = '0;
        ctrl_if.enable_stp_wrapper = 1'b0;
        ctrl_if.long_response = 1'b0;

        // Reset values.
        step();
        exp_out = 1'b1;
        exp_tc = 1'b0;
        exp_rc = 1'b0;
        exp_err = 1'b0;
        exp_resp = '0;
        chk_data = 1'b1;
        chk_en = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk_data = 1'b0;

        // Pin the CRC model with known SD CRC7 values.
        check("crc_model_cmd0", 136'(crc7_of(120'(40'h4000000000), 40)), 136'(7'h4A));
        check("crc_model_cmd8", 136'(crc7_of(120'(40'h48000001AA), 40)), 136'(7'h43));
        check("crc_model_r7", 136'(crc7_of(120'(40'h08000001AA), 40)), 136'(7'h09));

        tx_abort(40'h48000001AA, 10);
        tx_frame(40'h4000000000, 48'h400000000095, 0);
        tx_frame(40'h48000001AA, 48'h48000001AA87, 3);

        r7 = 136'(48'h08000001AA13);
        rx_frame(r7, 1'b0, -1, 1'b1, r7, 1'b0);
        rx_frame(r7 ^ (136'(1) << 20), 1'b0, -1, 1'b1, r7 ^ (136'(1) << 20), 1'b1);
        rx_frame(r7 & ~136'(1), 1'b0, -1, 1'b1, r7 & ~136'(1), 1'b1);

        cid = 120'h03534453443132338012345678_00A5;
        r2 = {8'h3F, cid, crc7_of(cid, 120), 1'b1};
        rx_frame(r2, 1'b1, -1, 1'b1, r2, 1'b0);
        rx_frame(r2, 1'b1, 75, 1'b0, '0, 1'b0);   // reset_wrapper with frame bit 60

        tx_frame(40'h4000000000, 48'h400000000095, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
